// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared encodings for the fetch PC unit.
//   im_ctrl_e  - control-flow mode of the D-stage instruction
//   EXC_*      - ExcCode values carried with the fetch address
//   is_branch  - true for the conditional-branch modes
package pc_unit_pkg;

    typedef enum logic [3:0] {
        IM_SEQ  = 4'd0,
        IM_J    = 4'd1,
        IM_JR   = 4'd2,
        IM_BEQ  = 4'd3,
        IM_BNE  = 4'd4,
        IM_BLEZ = 4'd5,
        IM_BGTZ = 4'd6,
        IM_BLTZ = 4'd7,
        IM_BGEZ = 4'd8
    } im_ctrl_e;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    function automatic logic is_branch(input logic [3:0] m);
        return (m >= IM_BEQ) && (m <= IM_BGEZ);
    endfunction

endpackage

// File: rtl/pc_branch_cmp.sv
// pc_branch_cmp: branch condition evaluation for the six compare modes.
//   d1, d2   - forwarded rs / rt values
//   im_ctrl  - control-flow mode (pc_unit_pkg encoding)
//   taken    - 1 when im_ctrl is a branch mode and its condition holds
module pc_branch_cmp
    import pc_unit_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] d1,
    input  logic [PC_W-1:0] d2,
    input  logic [3:0]      im_ctrl,
    output logic            taken
);

    logic neg;
    logic zero;

    assign neg  = d1[PC_W-1];
    assign zero = (d1 == '0);

    always_comb begin
        taken = 1'b0;
        taken = (im_ctrl == IM_BEQ)  ? (d1 == d2) :
                (im_ctrl == IM_BNE)  ? (d1 != d2) :
                (im_ctrl == IM_BLEZ) ? (neg || zero) :
                (im_ctrl == IM_BGTZ) ? (!neg && !zero) :
                (im_ctrl == IM_BLTZ) ? neg :
                (im_ctrl == IM_BGEZ) ? !neg : 1'b0;
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register with priority next-PC selection
// (req > block > eret > im_ctrl), fetch address-error code and redirect pulse.
//   clk, reset            - clock, asynchronous active-high reset
//   block, req, eret, epc - stall, exception entry, exception return
//   im_ctrl, d_pc, instr_index, offset, d1, d2 - D-stage control-flow inputs
//   pc, pc_exc, redirect  - fetch address, its ExcCode, non-sequential load pulse
//   taken_cnt, stall_cnt  - saturating statistics, built only with PC_STAT_EN
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] INIT_ADDR  = 32'h0000_3000,
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [PC_W-1:0] IM_LO      = 32'h0000_3000,
    parameter logic [PC_W-1:0] IM_HI      = 32'h0000_6FFF,
    parameter int              CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             block,
    input  logic             req,
    input  logic             eret,
    input  logic [PC_W-1:0]  epc,
    input  logic [3:0]       im_ctrl,
    input  logic [PC_W-1:0]  d_pc,
    input  logic [25:0]      instr_index,
    input  logic [15:0]      offset,
    input  logic [PC_W-1:0]  d1,
    input  logic [PC_W-1:0]  d2,
    output logic [PC_W-1:0]  pc,
    output logic [4:0]       pc_exc,
    output logic             redirect,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [PC_W-1:0] pc4;
    logic [PC_W-1:0] dpc4;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] j_target;
    logic [PC_W-1:0] npc;
    logic            taken;
    logic            flow;
    logic            hold;
    logic            bad;
    logic            redirect_n;

    pc_branch_cmp #(.PC_W(PC_W)) u_cmp (
        .d1      (d1),
        .d2      (d2),
        .im_ctrl (im_ctrl),
        .taken   (taken)
    );

    assign pc4       = pc + PC_W'(4);
    assign dpc4      = d_pc + PC_W'(4);
    assign br_target = dpc4 + {{(PC_W-18){offset[15]}}, offset, 2'b00};
    assign j_target  = {dpc4[PC_W-1:28], instr_index, 2'b00};
    assign flow      = (im_ctrl == IM_J) || (im_ctrl == IM_JR) || taken;
    assign hold      = block && !req;

    always_comb begin
        npc = pc4;
        npc = req                ? EXC_VECTOR :
              block              ? pc :
              eret               ? epc :
              (im_ctrl == IM_J)  ? j_target :
              (im_ctrl == IM_JR) ? d1 :
              taken              ? br_target : pc4;
    end

    // Wrapped sums land outside [IM_LO, IM_HI] and are flagged here.
    assign bad        = (npc[1:0] != 2'b00) || (npc < IM_LO) || (npc > IM_HI);
    assign redirect_n = req || (!block && (eret || flow));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= INIT_ADDR;
            pc_exc   <= EXC_INT;
            redirect <= 1'b0;
        end else begin
            pc       <= npc;
            pc_exc   <= hold ? pc_exc : (bad ? EXC_ADEL : EXC_INT);
            redirect <= redirect_n;
        end
    end

`ifdef PC_STAT_EN
    logic [CNT_W-1:0] taken_q;
    logic [CNT_W-1:0] stall_q;
    logic             take_evt;

    // Only branch/jump redirects count; req and eret redirects do not.
    assign take_evt = !req && !block && !eret && flow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_q <= '0;
            stall_q <= '0;
        end else begin
            if (take_evt && !(&taken_q)) taken_q <= taken_q + CNT_W'(1);
            if (hold && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign taken_cnt = taken_q;
    assign stall_cnt = stall_q;
`else
    assign taken_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed plus randomized checks of pc_unit against a
// behavioural next-PC model.
module tb_pc_unit;

    localparam int EXC_ADEL_V = 4;
`ifdef PC_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        block = 1'b0;
    logic        req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = '0;
    logic [3:0]  im_ctrl = '0;
    logic [31:0] d_pc = '0;
    logic [25:0] instr_index = '0;
    logic [15:0] offset = '0;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic [31:0] pc;
    logic [4:0]  pc_exc;
    logic        redirect;
    logic [15:0] taken_cnt;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] m_pc;
    int          m_exc;
    bit          m_redir;
    int          m_taken;
    int          m_stall;

    pc_unit dut (
        .clk(clk), .reset(reset), .block(block), .req(req), .eret(eret),
        .epc(epc), .im_ctrl(im_ctrl), .d_pc(d_pc), .instr_index(instr_index),
        .offset(offset), .d1(d1), .d2(d2), .pc(pc), .pc_exc(pc_exc),
        .redirect(redirect), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 32'h3000; m_exc = 0; m_redir = 0; m_taken = 0; m_stall = 0;
    endfunction

    function automatic void model_update();
        logic [31:0] n;
        logic [31:0] dpc4;
        logic signed [31:0] so;
        bit cond;
        bit flow;
        dpc4 = d_pc + 32'd4;
        so = $signed(offset);
        case (im_ctrl)
            4'd3: cond = (d1 == d2);
            4'd4: cond = (d1 != d2);
            4'd5: cond = ($signed(d1) <= 0);
            4'd6: cond = ($signed(d1) > 0);
            4'd7: cond = ($signed(d1) < 0);
            4'd8: cond = ($signed(d1) >= 0);
            default: cond = 0;
        endcase
        flow = cond || im_ctrl == 4'd1 || im_ctrl == 4'd2;
        if (req) n = 32'h4180;
        else if (block) n = m_pc;
        else if (eret) n = epc;
        else if (im_ctrl == 4'd1) n = {dpc4[31:28], instr_index, 2'b00};
        else if (im_ctrl == 4'd2) n = d1;
        else if (cond) n = dpc4 + so * 4;
        else n = m_pc + 32'd4;
        if (!(block && !req))
            m_exc = (n % 4 != 0 || n < 32'h3000 || n > 32'h6FFF) ? EXC_ADEL_V : 0;
        m_redir = req || (!block && (eret || flow));
        if (STAT && !req && !block && !eret && flow && m_taken < 65535) m_taken++;
        if (STAT && block && !req && m_stall < 65535) m_stall++;
        m_pc = n;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".exc"}, 32'(pc_exc), 32'(m_exc));
        check({tag, ".redir"}, 32'(redirect), 32'(m_redir));
        check({tag, ".tcnt"}, 32'(taken_cnt), 32'(m_taken));
        check({tag, ".scnt"}, 32'(stall_cnt), 32'(m_stall));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        logic [31:0] prev;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_pc", pc, 32'h3000);
        check("rst_redir", 32'(redirect), 32'd0);
        compare_all("rst");
        repeat (3) step("seq");
        check("seq_pc", pc, 32'h300C);

        d_pc = 32'h3004; im_ctrl = 4'd7; d1 = 32'hFFFF_FFFF; offset = 16'hFFFF;
        step("bltz_t");
        check("bltz_t_pc", pc, 32'h3004);
        check("bltz_t_redir", 32'(redirect), 32'd1);
        prev = pc;
        d1 = 32'h0;
        step("bltz_nt");
        check("bltz_nt_pc", pc, prev + 32'd4);
        check("bltz_nt_redir", 32'(redirect), 32'd0);

        d_pc = 32'h3100; im_ctrl = 4'd3; d1 = 32'd5; d2 = 32'd5; offset = 16'h0008;
        block = 1'b1; prev = pc;
        step("blk1");
        step("blk2");
        check("blk_pc", pc, prev);
        check("blk_redir", 32'(redirect), 32'd0);
        block = 1'b0;
        step("blk_rel");
        check("blk_rel_pc", pc, 32'h3124);

        req = 1'b1; block = 1'b1; eret = 1'b1; epc = 32'h3200;
        step("req");
        check("req_pc", pc, 32'h4180);
        check("req_redir", 32'(redirect), 32'd1);
        check("req_exc", 32'(pc_exc), 32'd0);
        req = 1'b0; block = 1'b0; eret = 1'b0;

        im_ctrl = 4'd2; d1 = 32'h3002;
        step("jr_mis");
        check("jr_mis_exc", 32'(pc_exc), 32'd4);
        d1 = 32'h7000;
        step("jr_hi");
        check("jr_hi_pc", pc, 32'h7000);
        check("jr_hi_exc", 32'(pc_exc), 32'd4);

        im_ctrl = 4'd1; d_pc = 32'h3000; instr_index = 26'h0000_D00;
        step("j");
        #2 reset = 1'b1;
        #1;
        check("arst_pc", pc, 32'h3000);
        check("arst_redir", 32'(redirect), 32'd0);
        check("arst_tcnt", 32'(taken_cnt), 32'd0);
        check("arst_scnt", 32'(stall_cnt), 32'd0);
        model_reset();
        im_ctrl = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        compare_all("arst");

        for (int i = 0; i < 1500; i++) begin
            req = ($urandom_range(0, 15) == 0);
            block = ($urandom_range(0, 3) == 0);
            eret = ($urandom_range(0, 7) == 0);
            epc = 32'h3000 + 32'($urandom_range(0, 32'h1000)) * 4;
            im_ctrl = 4'($urandom_range(0, 15));
            d_pc = 32'h3000 + 32'($urandom_range(0, 32'h0FFF)) * 4;
            instr_index = 26'($urandom);
            offset = 16'($urandom);
            d2 = $urandom_range(0, 3) == 0 ? 32'($urandom) : 32'($urandom_range(0, 3)) - 32'd1;
            case ($urandom_range(0, 3))
                0: d1 = d2;
                1: d1 = 32'h3000 + 32'($urandom_range(0, 32'h1000)) * 4;
                2: d1 = 32'($urandom_range(0, 2)) - 32'd1;
                default: d1 = $urandom;
            endcase
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised successor to the combinational next-PC calculator; owns the fetch PC register itself.
- Priority next-PC selection: exception entry > stall > eret > control-flow mode.
- Extended branch set: six compare modes, including sign/zero compares.
- Registered fetch-address exception code delivered alongside the PC, plus a redirect pulse for F/D flush.
- Sits at the head of the F stage and feeds the IM address and the F/D pipeline register.

Parameters:
PC_W, 32, PC/data width (MIPS build uses 32)
INIT_ADDR, 32'h0000_3000, PC value after reset
EXC_VECTOR, 32'h0000_4180, handler entry address taken on req
IM_LO, 32'h0000_3000, lowest legal fetch address
IM_HI, 32'h0000_6FFF, highest legal fetch byte address
CNT_W, 16, statistic counter width (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
block  in  1  stall: hold PC
req  in  1  exception/interrupt request from CP0
eret  in  1  eret in D stage
epc  in  PC_W  return address from CP0
im_ctrl  in  4  control-flow mode of D-stage instruction (package encoding)
d_pc  in  PC_W  address of D-stage instruction
instr_index  in  26  jump index
offset  in  16  branch offset
d1  in  PC_W  forwarded rs value
d2  in  PC_W  forwarded rt value
pc  out  PC_W  current fetch address
pc_exc  out  5  ExcCode for the fetch at pc (EXC_INT = none)
redirect  out  1  1-cycle pulse: pc was loaded from a non-sequential source
taken_cnt  out  CNT_W  taken branch/jump count (PC_STAT_EN only)
stall_cnt  out  CNT_W  stall-cycle count (PC_STAT_EN only)

Behaviour:
- Reset (async, active-high):
  - pc = INIT_ADDR, pc_exc = EXC_INT, redirect = 0, counters = 0.
  - Reset mid-stall or mid-redirect overrides everything.
- Combinational next-PC, priority order:
  1. req -> EXC_VECTOR
  2. block -> pc (hold)
  3. eret -> epc
  4. im_ctrl decode:
     - IM_SEQ -> pc+4
     - IM_J -> {dpc4[PC_W-1:28], instr_index, 2'b00}, where dpc4 = d_pc+4
     - IM_JR -> d1
     - branches: target = dpc4 + (sext(offset)<<2) when the condition holds, else pc+4
       - IM_BEQ: d1 == d2
       - IM_BNE: d1 != d2
       - IM_BLEZ: signed d1 <= 0
       - IM_BGTZ: signed d1 > 0
       - IM_BLTZ: d1[PC_W-1]
       - IM_BGEZ: !d1[PC_W-1]
     - undefined encodings -> pc+4
- Arithmetic: all sums modulo 2^PC_W; wrap is silent, and the range check catches it.
- Registered update every cycle on posedge clk: pc <= npc.
- pc_exc <= EXC_ADEL if npc[1:0] != 0, or npc < IM_LO, or npc > IM_HI; else EXC_INT.
  - On hold, pc_exc keeps its value.
  - pc_exc is always consistent with pc (same cycle); downstream gates fetch on pc_exc.
- redirect <= 1 when the selected source is req, eret, IM_J, IM_JR, or a taken branch, and block = 0 (req always pulses, even with block); else 0.
- Simultaneous events:
  - req + block -> vector taken (req wins).
  - eret + branch mode -> epc wins.
  - block + taken branch -> hold; the branch is re-evaluated next cycle with the same D inputs.
- No internal state beyond pc, pc_exc, redirect (+ counters); latency npc -> pc is 1 cycle.

Optional Feature:
Macro PC_STAT_EN.
- Defined: taken_cnt increments on each cycle in which redirect is being set by a branch/jump (not req/eret); stall_cnt increments each cycle block = 1 and req = 0. Both saturate at all-ones and reset to 0.
- Undefined: counter registers not built; taken_cnt and stall_cnt tied to 0.

Decomposition:
- Shared package/include (Gobals.v):
  - IM_SEQ=4'd0, IM_J=1, IM_JR=2, IM_BEQ=3, IM_BNE=4, IM_BLEZ=5, IM_BGTZ=6, IM_BLTZ=7, IM_BGEZ=8
  - EXC_INT=5'd0, EXC_ADEL=5'd4
- One sub-module: pc_branch_cmp (pure combinational; d1, d2, im_ctrl -> taken).
- Range/alignment check stays inline.

Test Plan:
- Reset deassert, no stimulus, 3 cycles -> pc = 0x3000, 0x3004, 0x3008; pc_exc = 0; redirect = 0.
- d_pc=0x3004, IM_BLTZ, d1=0xFFFF_FFFF, offset=0xFFFF -> pc = 0x3004 next cycle, redirect = 1; repeat with d1 = 0 -> pc = prev+4, redirect = 0.
- block=1, IM_BEQ taken, 2 cycles -> pc held, redirect = 0, stall_cnt += 2; release -> pc = target.
- req=1 with block=1 and eret=1 -> pc = 0x4180, redirect = 1, pc_exc = 0.
- IM_JR with d1=0x3002, then d1=0x7000 -> pc_exc = 4 both times, pc = 0x3002 / 0x7000 respectively.
- Assert reset asynchronously mid-cycle during a redirect -> pc = 0x3000 immediately, redirect = 0, counters = 0.
